// File: rtl/serial_compare_32bit_if.sv
// Handshake and operand/result bundle for the bit-serial 32-bit comparator.
interface serial_compare_32bit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] number1;
  logic [31:0] number2;
  logic        busy;
  logic        done;
  logic        equal;
  logic        less;
  logic        greater;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, is_signed, number1, number2,
    input  busy, done, equal, less, greater
  );

  // Comparator side.
  modport slave (
    input  start, is_signed, number1, number2,
    output busy, done, equal, less, greater
  );
endinterface

// File: rtl/serial_compare_32bit.sv
// Multi-cycle MSB-first bit-serial 32-bit comparator (signed/unsigned) with
// start/busy/done handshake; terminates at the first differing bit.
module serial_compare_32bit (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_compare_32bit_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [4:0]  idx;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
  logic        eq_q;
  logic        lt_q;
  logic        gt_q;

  logic        bit_a;
  logic        bit_b;
  logic        differ;
  logic        last_bit;
  logic        msb_flip;
  logic        accept;

  // Bit under examination and the decisions derived from it.
  always_comb begin
    bit_a    = a_q[idx];
    bit_b    = b_q[idx];
    differ   = bit_a ^ bit_b;
    last_bit = (idx == '0);
    // In signed mode the sign bit carries inverted weight.
    msb_flip = sgn_q && (idx == 5'd31);
    accept   = (state != SCAN) && bus.start;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: start is only honoured outside SCAN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? SCAN : IDLE;
      SCAN:    state_nx = (differ || last_bit) ? DONE : SCAN;
      DONE:    state_nx = bus.start ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status and held result outputs.
  always_comb begin
    bus.busy    = (state == SCAN);
    bus.done    = (state == DONE);
    bus.equal   = eq_q;
    bus.less    = lt_q;
    bus.greater = gt_q;
  end

  // Operand latch, bit index and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 5'd31;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else if (accept) begin
      idx   <= 5'd31;
      a_q   <= bus.number1;
      b_q   <= bus.number2;
      sgn_q <= bus.is_signed;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else if (state == SCAN) begin
      if (differ) begin
        if (bit_a ^ msb_flip) gt_q <= 1'b1;
        else                  lt_q <= 1'b1;
      end else if (last_bit) begin
        eq_q <= 1'b1;
      end else begin
        idx <= idx - 5'd1;
      end
    end
  end

endmodule
